// File: rtl/wb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bram_arbiter
//
// Two-master Wishbone classic arbiter that shares a single wb_bram slave
// between an instruction-fetch master (m0) and a load/store master (m1).
//
// Arbitration is done by a registered three-state grant FSM (IDLE, G0, G1).
// The granted master owns the slave for its whole CYC window. There is no
// preemption. When the owner drops CYC, a waiting master is handed the bus on
// the very next edge, with no idle bubble in between.
//
// Build option:
//   WB_BRAM_ARB_FIXED_PRIO_EN
//     defined   : any contention (in IDLE or at release) is won by m0.
//     undefined : round-robin. The master that was not granted last wins a
//                 tie. After reset m0 wins the first tie. This is the default.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   m0_* / m1_*                Wishbone classic slave-side ports, one per
//                              master: adr_i, dat_i, dat_o, we_i, sel_i,
//                              stb_i, cyc_i, ack_o
//   s_adr_o .. s_cyc_o         master-side port driving wb_bram
//   s_dat_i, s_ack_i           read data and acknowledge from wb_bram
//   grant_o                    one-hot current owner {m1,m0}; 00 when idle
// -----------------------------------------------------------------------------
module wb_bram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,

  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,

  // master 1 (data load/store)
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,

  // shared slave (wb_bram)
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic                    s_ack_i,

  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t     state_reg;
  logic       last_grant_reg;   // 0: m0 was granted last, 1: m1
  logic [1:0] grant_reg;        // one-hot {m1,m0}, kept in step with state_reg

  // Master that wins when both request at the same decision point.
  logic       contend_winner;

`ifdef WB_BRAM_ARB_FIXED_PRIO_EN
  // Fetch has fixed priority, so the grant history is ignored.
  assign contend_winner = 1'b0;
`else
  // Round-robin: the master that was not served last wins.
  assign contend_winner = ~last_grant_reg;
`endif

  // ---------------------------------------------------------------------------
  // Grant FSM
  // All decisions are registered. A request seen in IDLE is granted one edge
  // later, and the slave sees the granted master from then on.
  // last_grant_reg records every entry into G0/G1. Re-assigning it while a
  // grant is held leaves the value unchanged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (contend_winner) begin
              state_reg      <= G1;
              last_grant_reg <= 1'b1;
              grant_reg      <= 2'b10;
            end else begin
              state_reg      <= G0;
              last_grant_reg <= 1'b0;
              grant_reg      <= 2'b01;
            end
          end else if (m0_cyc_i) begin
            state_reg      <= G0;
            last_grant_reg <= 1'b0;
            grant_reg      <= 2'b01;
          end else if (m1_cyc_i) begin
            state_reg      <= G1;
            last_grant_reg <= 1'b1;
            grant_reg      <= 2'b10;
          end else begin
            state_reg <= IDLE;
            grant_reg <= 2'b00;
          end
        end

        G0: begin
          // m0 keeps the bus for as long as its CYC stays high.
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state_reg      <= G1;
              last_grant_reg <= 1'b1;
              grant_reg      <= 2'b10;
            end else begin
              state_reg <= IDLE;
              grant_reg <= 2'b00;
            end
          end
        end

        G1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state_reg      <= G0;
              last_grant_reg <= 1'b0;
              grant_reg      <= 2'b01;
            end else begin
              state_reg <= IDLE;
              grant_reg <= 2'b00;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o = grant_reg;

  // ---------------------------------------------------------------------------
  // Slave-side multiplexer
  // This is combinational from the registered state only, so no master input
  // can pass through to the slave without a grant. In IDLE the slave sees an
  // all-zero bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    case (state_reg)
      G0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_stb_o = m0_stb_i;
        s_cyc_o = m0_cyc_i;
      end
      G1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_stb_o = m1_stb_i;
        s_cyc_o = m1_cyc_i;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Acknowledge steering
  // The bram ack is registered from the previous cycle's request, so an ack
  // can still be in flight after a reset or a grant change. Gating it with the
  // current grant stops that ack from reaching a master that does not own the
  // bus. Read data is broadcast to both masters, and only ack qualifies it.
  // ---------------------------------------------------------------------------
  logic [1:0] ack_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = s_ack_i & grant_reg[gi];
    end
  endgenerate

  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed testbench for wb_bram_arbiter. A small behavioural wb_bram sits
// behind the arbiter: its ack and read data are registered, and it holds ack
// low on the cycle after an ack. Ack is deliberately unaffected by rst, so a
// reset can leave a bram ack in flight.
module tb_wb_bram_arbiter;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat;
  logic [DW-1:0] s_rdat = '0;
  logic          m0_we, m1_we, s_we;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_stb, m1_stb, m0_cyc, m1_cyc, s_stb, s_cyc;
  logic          m0_ack, m1_ack;
  logic          s_ack = 1'b0;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack),
    .grant_o(grant)
  );

  // Behavioural wb_bram: 512 x 32-bit words, word index taken from adr[10:2].
  logic [DW-1:0] mem [0:511];

  always @(posedge clk) begin
    if (s_cyc && s_stb && !s_ack) begin
      s_ack  <= 1'b1;
      s_rdat <= mem[s_adr[AW-1:2]];
      if (s_we) begin
        for (int b = 0; b < SW; b++)
          if (s_sel[b]) mem[s_adr[AW-1:2]][b*8 +: 8] <= s_wdat[b*8 +: 8];
      end
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq_got [0:5];
  int         n_grants;
  int         beats;
  int         cyc_cnt;
  logic [1:0] prev_grant;
  logic       both_ack;
  logic       m0_drop, m1_drop;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[4]  = 32'h1234_5678;   // byte address 0x010
    mem[12] = 32'h1122_3344;   // byte address 0x030
    rst = 1'b1;
    m0_adr = '0; m0_wdat = '0; m0_we = 0; m0_sel = '0; m0_stb = 0; m0_cyc = 0;
    m1_adr = '0; m1_wdat = '0; m1_we = 0; m1_sel = '0; m1_stb = 0; m1_cyc = 0;

    // 1: reset state
    step(); step();
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_acks", {m1_ack, m0_ack}, 2'b00);
    rst = 1'b0;
    step();

    // 2: m0 single read of 0x010
    m0_adr = 11'h010; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1;
    step();
    check("t2_grant", grant, 2'b01);
    check("t2_ack_early", m0_ack, 1'b0);
    step();
    check("t2_m0_ack", m0_ack, 1'b1);
    check("t2_m0_dat", m0_rdat, 32'h1234_5678);
    check("t2_m1_ack", m1_ack, 1'b0);
    m0_cyc = 0; m0_stb = 0;
    step();
    check("t2_idle", grant, 2'b00);

    // 3: simultaneous request right after reset, so m0 must win
    rst = 1'b1; step(); rst = 1'b0;
    m0_adr = 11'h010; m0_cyc = 1; m0_stb = 1;
    m1_adr = 11'h020; m1_wdat = 32'hDEAD_BEEF; m1_we = 1; m1_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1;
    step();
    check("t3_grant_g0", grant, 2'b01);
    check("t3_s_adr", s_adr, 11'h010);
    step();
    check("t3_acks_g0", {m1_ack, m0_ack}, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    step();
    check("t3_handoff", grant, 2'b10);
    check("t3_s_adr1", s_adr, 11'h020);
    step();
    check("t3_acks_g1", {m1_ack, m0_ack}, 2'b10);
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step();
    check("t3_mem", mem[8], 32'hDEAD_BEEF);
    check("t3_idle", grant, 2'b00);

    // 4: round-robin. Both masters keep requesting, and each releases for one
    //    cycle after every ack.
    m0_adr = 11'h010; m1_adr = 11'h010;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    n_grants = 0; prev_grant = 2'b00; both_ack = 0; cyc_cnt = 0;
    while (n_grants < 6 && cyc_cnt < 80) begin
      step();
      cyc_cnt++;
      if (m0_ack && m1_ack) both_ack = 1;
      if (grant != 2'b00 && grant != prev_grant) begin
        seq_got[n_grants] = grant;
        n_grants++;
      end
      prev_grant = grant;
      m0_drop = m0_ack; m1_drop = m1_ack;
      m0_cyc = !m0_drop; m0_stb = !m0_drop;
      m1_cyc = !m1_drop; m1_stb = !m1_drop;
    end
    check("t4_grant_count", n_grants, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_seq%0d", i), seq_got[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    check("t4_no_double_ack", both_ack, 1'b0);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step(); step(); step();
    check("t4_idle", grant, 2'b00);

    // 5: m1 holds CYC for 4 write beats while m0 waits. The write is a
    //    byte-lane write with sel=0010.
    m1_adr = 11'h030; m1_wdat = 32'h0000_AB00; m1_sel = 4'b0010; m1_we = 1;
    m1_cyc = 1; m1_stb = 1;
    step();
    check("t5_grant_g1", grant, 2'b10);
    m0_adr = 11'h030; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1;
    beats = 0; cyc_cnt = 0; both_ack = 0;
    while (beats < 4 && cyc_cnt < 20) begin
      step();
      cyc_cnt++;
      if (grant != 2'b10 || m0_ack) both_ack = 1;
      if (m1_ack) beats++;
    end
    check("t5_beats", beats, 4);
    check("t5_no_switch", both_ack, 1'b0);
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step();
    check("t5_handoff", grant, 2'b01);
    cyc_cnt = 0;
    while (!m0_ack && cyc_cnt < 10) begin
      step();
      cyc_cnt++;
    end
    check("t5_m0_ack", m0_ack, 1'b1);
    check("t5_m0_dat", m0_rdat, 32'h1122_AB44);
    m0_cyc = 0; m0_stb = 0;
    step(); step();

    // 6: reset pulsed while m1 is granted with STB high, which leaves a bram
    //    ack in flight.
    m1_adr = 11'h010; m1_sel = 4'hF; m1_cyc = 1; m1_stb = 1;
    step();
    check("t6_grant_g1", grant, 2'b10);
    rst = 1'b1;
    step();
    check("t6_grant", grant, 2'b00);
    check("t6_s_bus", {s_cyc, s_stb}, 2'b00);
    check("t6_acks", {m1_ack, m0_ack}, 2'b00);
    rst = 1'b0; m1_cyc = 0; m1_stb = 0;
    step();
    check("t6_idle_after", grant, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
